// File: rtl/hs_width_packer_pkg.sv
// Shared handshake helpers: lane-counter sizing and packing-ratio legality.
package hs_width_packer_pkg;

   // Bits needed to count lanes 0..ratio-1; never less than one.
   function automatic int unsigned cnt_width(input int unsigned ratio);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << w) < ratio) w = i + 1;
      end
      return w;
   endfunction

   function automatic bit ratio_legal(input int unsigned ratio);
      return (ratio >= 2) && (ratio <= 16) && ((ratio & (ratio - 1)) == 0);
   endfunction

endpackage

// File: rtl/hs_width_packer_if.sv
// Beat-in / word-out handshake bundle for the width packer.
interface hs_width_packer_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned RATIO = 4
);
   logic                     src_vaild;
   logic [WIDTH-1:0]         src_data_in;
   logic                     src_last;
   logic                     src_ready;
   logic                     dst_vaild;
   logic [WIDTH*RATIO-1:0]   dst_data_out;
   logic [RATIO-1:0]         dst_keep;
   logic                     dst_last;
   logic                     dst_ready;

   modport master (
      output src_vaild, src_data_in, src_last, dst_ready,
      input  src_ready, dst_vaild, dst_data_out, dst_keep, dst_last
   );

   modport slave (
      input  src_vaild, src_data_in, src_last, dst_ready,
      output src_ready, dst_vaild, dst_data_out, dst_keep, dst_last
   );
endinterface

// File: rtl/hs_width_packer.sv
// Packs RATIO narrow beats into one wide word, LSB-first, with per-lane keep
// and early packet close on src_last.
module hs_width_packer
   import hs_width_packer_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned RATIO = 4
) (
   input  logic               clk,
   input  logic               s_rst,
   hs_width_packer_if.slave   bus
);

   localparam int unsigned CW = cnt_width(RATIO);
   localparam int unsigned OW = WIDTH * RATIO;

   if (!ratio_legal(RATIO)) begin : g_bad_ratio
      $error("hs_width_packer: RATIO must be a power of two in 2..16");
   end

   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_acc [RATIO];
   logic             r_dst_vaild;
   logic [OW-1:0]    r_dst_data;
   logic [RATIO-1:0] r_dst_keep;
   logic             r_dst_last;

   logic             w_src_ready;
   logic             w_accept;
   logic             w_complete;
   logic             w_xfer;
   logic [OW-1:0]    w_word;
   logic [RATIO-1:0] w_keep;

   // Output stage may refill in the same cycle it drains.
   assign w_src_ready = s_rst || !r_dst_vaild || bus.dst_ready;
   assign w_accept    = bus.src_vaild && w_src_ready;
   assign w_complete  = w_accept && ((r_cnt == CW'(RATIO - 1)) || bus.src_last);
   assign w_xfer      = r_dst_vaild && bus.dst_ready;

   // Stored lanes below cnt, current beat at cnt, zero above.
   always_comb begin
      w_word = '0;
      w_keep = '0;
      for (int unsigned k = 0; k < RATIO; k++) begin
         if (k < 32'(r_cnt)) begin
            w_word[k*WIDTH +: WIDTH] = r_acc[k];
            w_keep[k]                = 1'b1;
         end else if (k == 32'(r_cnt)) begin
            w_word[k*WIDTH +: WIDTH] = bus.src_data_in;
            w_keep[k]                = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (s_rst) begin
         r_cnt       <= '0;
         r_dst_vaild <= 1'b0;
         r_dst_data  <= '0;
         r_dst_keep  <= '0;
         r_dst_last  <= 1'b0;
         for (int unsigned k = 0; k < RATIO; k++) r_acc[k] <= '0;
      end else begin
         if (w_complete) begin
            r_cnt <= '0;
            for (int unsigned k = 0; k < RATIO; k++) r_acc[k] <= '0;
         end else if (w_accept) begin
            r_cnt        <= r_cnt + CW'(1);
            r_acc[r_cnt] <= bus.src_data_in;
         end

         if (w_complete) begin
            r_dst_vaild <= 1'b1;
            r_dst_data  <= w_word;
            r_dst_keep  <= w_keep;
            r_dst_last  <= bus.src_last;
         end else if (w_xfer) begin
            r_dst_vaild <= 1'b0;
         end
      end
   end

   assign bus.src_ready    = w_src_ready;
   assign bus.dst_vaild    = r_dst_vaild;
   assign bus.dst_data_out = r_dst_data;
   assign bus.dst_keep     = r_dst_keep;
   assign bus.dst_last     = r_dst_last;

endmodule

// File: tb/tb_hs_width_packer.sv
// Self-checking bench for hs_width_packer (WIDTH=8, RATIO=4): directed vector
// table with hand-derived results, then random traffic against a queue model.
module tb_hs_width_packer;

   localparam int unsigned W = 8;
   localparam int unsigned R = 4;

   logic clk = 1'b0;
   logic s_rst;
   always #5 clk = ~clk;

   hs_width_packer_if #(.WIDTH(W), .RATIO(R)) bus ();

   hs_width_packer #(.WIDTH(W), .RATIO(R)) u_dut (
      .clk   (clk),
      .s_rst (s_rst),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference: pending beats of the open word plus the visible output word.
   logic [W-1:0] m_q[$];
   bit           m_vld;
   logic [31:0]  m_data;
   logic [3:0]   m_keep;
   bit           m_last;
   bit           m_rdy;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
      end
   endtask

   // One clock: drive, check ready, clock the model with the DUT, check outputs.
   task automatic step(input bit rst, input bit v, input logic [W-1:0] d,
                       input bit l, input bit dr);
      bit acc, xfer;
      logic [31:0] word;
      s_rst           = rst;
      bus.src_vaild   = v;
      bus.src_data_in = d;
      bus.src_last    = l;
      bus.dst_ready   = dr;
      m_rdy = rst || !m_vld || dr;
      #2;
      chk("src_ready", 32'(bus.src_ready), 32'(m_rdy));
      @(posedge clk);
      if (rst) begin
         m_q.delete();
         m_vld  = 1'b0;
         m_data = '0;
         m_keep = '0;
         m_last = 1'b0;
      end else begin
         acc  = v && m_rdy;
         xfer = m_vld && dr;
         if (xfer) m_vld = 1'b0;
         if (acc) begin
            m_q.push_back(d);
            if (m_q.size() == R || l) begin
               word = '0;
               foreach (m_q[k]) word |= 32'(m_q[k]) << (W * k);
               m_data = word;
               m_keep = 4'((1 << m_q.size()) - 1);
               m_last = l;
               m_vld  = 1'b1;
               m_q.delete();
            end
         end
      end
      #1;
      chk("dst_vaild", 32'(bus.dst_vaild), 32'(m_vld));
      if (m_vld || rst) begin
         chk("dst_data_out", bus.dst_data_out, m_data);
         chk("dst_keep", 32'(bus.dst_keep), 32'(m_keep));
         chk("dst_last", 32'(bus.dst_last), 32'(m_last));
      end
   endtask

   typedef struct {
      bit          rst;
      bit          v;
      logic [7:0]  d;
      bit          l;
      bit          dr;
      bit          e_rdy;
      bit          e_vld;
      logic [31:0] e_data;
      logic [3:0]  e_keep;
      bit          e_last;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(bit rst, bit v, logic [7:0] d, bit l, bit dr,
                               bit e_rdy, bit e_vld, logic [31:0] e_data,
                               logic [3:0] e_keep, bit e_last);
      vec_t t;
      t.rst = rst; t.v = v; t.d = d; t.l = l; t.dr = dr;
      t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_data = e_data;
      t.e_keep = e_keep; t.e_last = e_last;
      return t;
   endfunction

   initial begin
      // Full word, short packet, single-beat packet overlapping a drain.
      vt.push_back(mk(0,1,8'h11,0,1, 1,0,32'h0,4'h0,0));
      vt.push_back(mk(0,1,8'h22,0,1, 1,0,32'h0,4'h0,0));
      vt.push_back(mk(0,1,8'h33,0,1, 1,0,32'h0,4'h0,0));
      vt.push_back(mk(0,1,8'h44,0,1, 1,1,32'h44332211,4'hF,0));
      vt.push_back(mk(0,1,8'hA1,0,1, 1,0,32'h0,4'h0,0));
      vt.push_back(mk(0,1,8'hA2,1,1, 1,1,32'h0000A2A1,4'h3,1));
      vt.push_back(mk(0,1,8'h5A,1,1, 1,1,32'h0000005A,4'h1,1));
      vt.push_back(mk(0,0,8'h00,0,1, 1,0,32'h0,4'h0,0));
      // Eight back-to-back beats.
      for (int i = 1; i <= 8; i++)
         vt.push_back(mk(0,1,8'(i),0,1, 1,(i % 4) == 0,
                         (i == 4) ? 32'h04030201 : 32'h08070605,
                         ((i % 4) == 0) ? 4'hF : 4'h0,0));
      vt.push_back(mk(0,0,8'h00,0,1, 1,0,32'h0,4'h0,0));
      // Backpressure: word held, no acceptance until dst_ready.
      vt.push_back(mk(0,1,8'h11,0,0, 1,0,32'h0,4'h0,0));
      vt.push_back(mk(0,1,8'h22,0,0, 1,0,32'h0,4'h0,0));
      vt.push_back(mk(0,1,8'h33,0,0, 1,0,32'h0,4'h0,0));
      vt.push_back(mk(0,1,8'h44,0,0, 1,1,32'h44332211,4'hF,0));
      vt.push_back(mk(0,1,8'hEE,0,0, 0,1,32'h44332211,4'hF,0));
      vt.push_back(mk(0,1,8'hEE,1,0, 0,1,32'h44332211,4'hF,0));
      vt.push_back(mk(0,1,8'hC1,0,1, 1,0,32'h0,4'h0,0));
      vt.push_back(mk(0,1,8'hC2,0,1, 1,0,32'h0,4'h0,0));
      // Reset drops the partial word; next packet has no stale lanes.
      vt.push_back(mk(1,1,8'h99,0,1, 1,0,32'h0,4'h0,0));
      vt.push_back(mk(0,1,8'h55,0,1, 1,0,32'h0,4'h0,0));
      vt.push_back(mk(0,1,8'h66,0,1, 1,0,32'h0,4'h0,0));
      vt.push_back(mk(0,1,8'h77,0,1, 1,0,32'h0,4'h0,0));
      vt.push_back(mk(0,1,8'h88,0,1, 1,1,32'h88776655,4'hF,0));
      // Reset discards a stalled output word.
      vt.push_back(mk(0,0,8'h00,0,0, 0,1,32'h88776655,4'hF,0));
      vt.push_back(mk(1,0,8'h00,0,0, 1,0,32'h0,4'h0,0));
      vt.push_back(mk(0,0,8'h00,0,1, 1,0,32'h0,4'h0,0));
      vt.push_back(mk(0,0,8'h00,0,1, 1,0,32'h0,4'h0,0));

      m_vld = 1'b0; m_data = '0; m_keep = '0; m_last = 1'b0;
      step(1, 0, '0, 0, 1);
      step(1, 0, '0, 0, 1);
      chk("reset_vaild", 32'(bus.dst_vaild), 32'h0);
      chk("reset_data", bus.dst_data_out, 32'h0);
      chk("reset_keep", 32'(bus.dst_keep), 32'h0);

      for (int i = 0; i < vt.size(); i++) begin
         s_rst           = vt[i].rst;
         bus.src_vaild   = vt[i].v;
         bus.src_data_in = vt[i].d;
         bus.src_last    = vt[i].l;
         bus.dst_ready   = vt[i].dr;
         #1;
         chk($sformatf("vec%0d_ready", i), 32'(bus.src_ready), 32'(vt[i].e_rdy));
         step(vt[i].rst, vt[i].v, vt[i].d, vt[i].l, vt[i].dr);
         chk($sformatf("vec%0d_vaild", i), 32'(bus.dst_vaild), 32'(vt[i].e_vld));
         if (vt[i].e_vld) begin
            chk($sformatf("vec%0d_data", i), bus.dst_data_out, vt[i].e_data);
            chk($sformatf("vec%0d_keep", i), 32'(bus.dst_keep), 32'(vt[i].e_keep));
            chk($sformatf("vec%0d_last", i), 32'(bus.dst_last), 32'(vt[i].e_last));
         end
      end

      // Random traffic with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 3) != 0,
              8'($urandom),
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 3) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
